ysyx_ifu_fetch_queue: RTL and testbench
=======================================

YSYX_IFU_FETCH_QUEUE -- requirements
Module: ysyx_ifu_fetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default `YSYX_XLEN, meaning PC/cause width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning entry count; power of two, >= 2.
REQ-003 SHALL have one clock and a synchronous, active-low reset: clock input 1 (all state updates on rising edge), reset input 1 (0 = reset, sampled on clock edge).
REQ-004 SHALL have port flush  input 1, meaning pipeline redirect; discards all entries.
REQ-005 SHALL have ports in_valid input 1 and in_ready output 1, meaning the IFU-side handshake.
REQ-006 SHALL have ports in_inst input 32, in_pc input XLEN, in_pnpc input XLEN, in_trap input 1 and in_cause input XLEN, meaning the IFU-side payload.
REQ-007 SHALL have ports out_valid output 1 and out_ready input 1, meaning the IDU-side handshake.
REQ-008 SHALL have ports out_inst output 32, out_pc output XLEN, out_pnpc output XLEN, out_trap output 1 and out_cause output XLEN, meaning the head entry payload.
REQ-009 SHALL have port count output $clog2(DEPTH)+1, meaning occupied entries.
REQ-010 SHALL have port trap_fence output 1, meaning a trap entry is held and enqueue is blocked.

Function
REQ-011 SHALL be a registered circular FIFO: head/tail pointers $clog2(DEPTH) bits, wrap modulo DEPTH, with no combinational path from in_* to out_*.
REQ-012 SHALL enqueue when in_valid && in_ready; the entry is visible on out_* no earlier than the next cycle (latency 1).
REQ-013 SHALL dequeue when out_valid && out_ready; head advances by 1.
REQ-014 SHALL drive out_valid = (count != 0) and out_* = storage[head]; out_* payload is don't-care when out_valid = 0.
REQ-015 SHALL drive in_ready = (count < DEPTH) && !trap_fence && !flush, with no dependence on out_ready.
REQ-016 SHALL, on simultaneous enqueue and dequeue with 0 < count < DEPTH, leave count unchanged and advance both pointers.
REQ-017 SHALL NOT accept when full, even if the head dequeues in the same cycle; count goes DEPTH -> DEPTH-1.
REQ-018 SHALL set trap_fence the cycle after an enqueue with in_trap = 1 and hold it until flush or reset; a dequeue of the trap entry does not clear it.
REQ-019 SHALL give flush priority over enqueue and dequeue: on the next edge, count = 0, head = tail = 0, trap_fence = 0; a same-cycle in_* transfer is dropped, and out_valid may still be high during the flush cycle but the consumer treats it as killed.
REQ-020 SHALL keep every payload field bit-exact end to end, with no width conversion.
REQ-021 SHALL keep count in the range 0..DEPTH at all times.

Reset
REQ-022 SHALL, while reset = 0 at an edge, set head = 0, tail = 0, count = 0 and trap_fence = 0, so that out_valid = 0 and in_ready = 0 during reset.
REQ-023 SHALL restore in_ready = 1 the first cycle after reset deasserts.
REQ-024 SHALL, on reset mid-operation, discard all entries with no partial dequeue; entry storage need not be cleared.
REQ-025 SHALL have higher priority for reset than for flush.

Verification
REQ-026 SHALL cover fill to full: DEPTH=4, out_ready=0, 5 pushes pc=0x80000000+4k -> first 4 accepted, count=4, in_ready=0, 5th held; then out_ready=1 -> pcs pop in order 0x80000000..0x8000000C.
REQ-027 SHALL cover steady streaming: in_valid=out_ready=1 for 20 cycles from empty -> count settles at 1, one instruction per cycle, order preserved, including pointer wrap past index 3.
REQ-028 SHALL cover the trap fence: push pc=0x100 with trap=1 and cause=2, then pc=0x104 -> 0x104 not accepted, trap_fence=1; drain -> out_trap=1, out_cause=2; flush -> trap_fence=0 and in_ready=1.
REQ-029 SHALL cover flush with simultaneous push: count=3, flush=1, in_valid=1, out_ready=1 -> next cycle count=0, out_valid=0, and the pushed entry never appears.
REQ-030 SHALL cover reset mid-stream: count=2, reset=0 for 1 cycle -> count=0, out_valid=0; the next push pc=0x200 appears at out_pc one cycle later.
REQ-031 SHALL cover the full-boundary simultaneous case: count=4, out_ready=1, in_valid=1 -> in_ready=0, count becomes 3, and the push is accepted on the following cycle.

Source files
------------

// File: rtl/ysyx_ifu_fetch_queue.sv
// Fetch queue between IFU and IDU: a registered circular FIFO carrying
// instruction, PC, predicted next PC and trap information. Once a trapping
// entry is accepted, further enqueues are fenced off until a flush.
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

module ysyx_ifu_fetch_queue #(
    parameter int XLEN  = `YSYX_XLEN,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,

    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_inst,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [XLEN-1:0]            in_pnpc,
    input  logic                       in_trap,
    input  logic [XLEN-1:0]            in_cause,

    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_inst,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_pnpc,
    output logic                       out_trap,
    output logic [XLEN-1:0]            out_cause,

    output logic [$clog2(DEPTH):0]     count,
    output logic                       trap_fence
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Entry storage; payload only, never reset.
    logic [31:0]      inst_mem  [DEPTH];
    logic [XLEN-1:0]  pc_mem    [DEPTH];
    logic [XLEN-1:0]  pnpc_mem  [DEPTH];
    logic             trap_mem  [DEPTH];
    logic [XLEN-1:0]  cause_mem [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] occupancy;
    logic             fence;

    logic             full;
    logic             enq;
    logic             deq;

    // Handshake decode. in_ready depends only on registered state plus
    // flush/reset, never on out_ready, so a full queue cannot accept even
    // when the head leaves in the same cycle.
    always_comb begin
        full      = (occupancy == CNT_W'(DEPTH));
        in_ready  = reset && !full && !fence && !flush;
        out_valid = (occupancy != '0);
        enq       = in_valid && in_ready;
        deq       = out_valid && out_ready;
    end

    // Head entry presented directly from storage; no path from in_* here.
    always_comb begin
        out_inst  = inst_mem[head];
        out_pc    = pc_mem[head];
        out_pnpc  = pnpc_mem[head];
        out_trap  = trap_mem[head];
        out_cause = cause_mem[head];
    end

    assign count      = occupancy;
    assign trap_fence = fence;

    // Payload write at the tail on every accepted enqueue.
    always_ff @(posedge clock) begin
        if (enq) begin
            inst_mem[tail]  <= in_inst;
            pc_mem[tail]    <= in_pc;
            pnpc_mem[tail]  <= in_pnpc;
            trap_mem[tail]  <= in_trap;
            cause_mem[tail] <= in_cause;
        end
    end

    // Pointer, occupancy and fence state; reset beats flush, flush beats
    // any same-cycle transfer.
    always_ff @(posedge clock) begin
        if (!reset) begin
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
            fence     <= 1'b0;
        end else if (flush) begin
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
            fence     <= 1'b0;
        end else begin
            if (enq) begin
                tail <= tail + PTR_W'(1);
            end
            if (deq) begin
                head <= head + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   occupancy <= occupancy + CNT_W'(1);
                2'b01:   occupancy <= occupancy - CNT_W'(1);
                default: occupancy <= occupancy;
            endcase
            // The fence survives dequeue of the trapping entry itself; only
            // a redirect (flush) or reset reopens the queue.
            if (enq && in_trap) begin
                fence <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_ifu_fetch_queue.sv
// Directed bench for ysyx_ifu_fetch_queue with DEPTH=4, XLEN=32.
module tb_ysyx_ifu_fetch_queue;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic [31:0] in_pnpc;
    logic        in_trap;
    logic [31:0] in_cause;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_pnpc;
    logic        out_trap;
    logic [31:0] out_cause;
    logic [2:0]  count;
    logic        trap_fence;

    int n_assert = 0;
    int n_fail   = 0;

    ysyx_ifu_fetch_queue #(.XLEN(32), .DEPTH(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_inst    (in_inst),
        .in_pc      (in_pc),
        .in_pnpc    (in_pnpc),
        .in_trap    (in_trap),
        .in_cause   (in_cause),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_inst   (out_inst),
        .out_pc     (out_pc),
        .out_pnpc   (out_pnpc),
        .out_trap   (out_trap),
        .out_cause  (out_cause),
        .count      (count),
        .trap_fence (trap_fence)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic trap, input logic [31:0] cause);
        in_valid = v;
        in_pc    = pc;
        in_inst  = pc ^ 32'hA5A5_0013;
        in_pnpc  = pc + 32'd4;
        in_trap  = trap;
        in_cause = cause;
    endtask

    initial begin
        reset     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 32'h0);

        // Reset state
        tick();
        tick();
        check("rst_count", 64'(count), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_fence", 64'(trap_fence), 64'd0);
        reset = 1'b1;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Fill to full with out_ready low; fifth push is held
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 32'h8000_0000 + 32'(4 * k), 1'b0, 32'h0);
            #1;
            check($sformatf("fill_in_ready_%0d", k), 64'(in_ready), (k < 4) ? 64'd1 : 64'd0);
            tick();
            check($sformatf("fill_count_%0d", k), 64'(count), (k < 4) ? 64'(k + 1) : 64'd4);
        end
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_head_pc", 64'(out_pc), 64'h8000_0000);
        check("full_head_inst", 64'(out_inst), 64'(32'h8000_0000 ^ 32'hA5A5_0013));
        check("full_head_pnpc", 64'(out_pnpc), 64'h8000_0004);

        // Full boundary: pop while pushing 0x80000010; push waits one cycle
        out_ready = 1'b1;
        #1;
        check("fullpop_in_ready", 64'(in_ready), 64'd0);
        tick();
        check("fullpop_count1", 64'(count), 64'd3);
        check("fullpop_pc1", 64'(out_pc), 64'h8000_0004);
        check("fullpop_in_ready1", 64'(in_ready), 64'd1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        check("fullpop_count2", 64'(count), 64'd3);
        check("fullpop_pc2", 64'(out_pc), 64'h8000_0008);
        tick();
        check("drain_count3", 64'(count), 64'd2);
        check("drain_pc3", 64'(out_pc), 64'h8000_000C);
        tick();
        check("drain_count4", 64'(count), 64'd1);
        check("drain_pc4", 64'(out_pc), 64'h8000_0010);
        tick();
        check("drain_count5", 64'(count), 64'd0);
        check("drain_valid5", 64'(out_valid), 64'd0);

        // Steady streaming from empty, crossing pointer wrap several times
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 32'h1000 + 32'(4 * i), 1'b0, 32'h0);
            tick();
            check($sformatf("stream_count_%0d", i), 64'(count), 64'd1);
            check($sformatf("stream_pc_%0d", i), 64'(out_pc), 64'(32'h1000 + 32'(4 * i)));
        end
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        check("stream_empty", 64'(count), 64'd0);

        // Trap fence
        out_ready = 1'b0;
        drive(1'b1, 32'h100, 1'b1, 32'd2);
        tick();
        check("trap_fence_set", 64'(trap_fence), 64'd1);
        drive(1'b1, 32'h104, 1'b0, 32'd0);
        #1;
        check("trap_in_ready", 64'(in_ready), 64'd0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        check("trap_count", 64'(count), 64'd1);
        check("trap_out_trap", 64'(out_trap), 64'd1);
        check("trap_out_cause", 64'(out_cause), 64'd2);
        check("trap_out_pc", 64'(out_pc), 64'h100);
        out_ready = 1'b1;
        tick();
        check("trap_drained", 64'(count), 64'd0);
        check("trap_fence_hold", 64'(trap_fence), 64'd1);
        check("trap_in_ready_hold", 64'(in_ready), 64'd0);
        flush = 1'b1;
        #1;
        check("flush_in_ready", 64'(in_ready), 64'd0);
        tick();
        flush = 1'b0;
        #1;
        check("flush_fence_clr", 64'(trap_fence), 64'd0);
        check("flush_in_ready_back", 64'(in_ready), 64'd1);

        // Flush with simultaneous push and pop
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h300 + 32'(4 * k), 1'b0, 32'h0);
            tick();
        end
        check("pre_flush_count", 64'(count), 64'd3);
        drive(1'b1, 32'h30C, 1'b0, 32'h0);
        flush     = 1'b1;
        out_ready = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        check("flush_count", 64'(count), 64'd0);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        tick();
        check("flush_stays_empty", 64'(out_valid), 64'd0);
        drive(1'b1, 32'h310, 1'b0, 32'h0);
        out_ready = 1'b0;
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        check("postflush_pc", 64'(out_pc), 64'h310);
        out_ready = 1'b1;
        tick();
        check("postflush_empty", 64'(count), 64'd0);

        // Reset mid-stream
        out_ready = 1'b0;
        drive(1'b1, 32'h400, 1'b0, 32'h0);
        tick();
        drive(1'b1, 32'h404, 1'b0, 32'h0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        check("pre_rst_count", 64'(count), 64'd2);
        reset = 1'b0;
        tick();
        check("midrst_count", 64'(count), 64'd0);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        reset = 1'b1;
        drive(1'b1, 32'h200, 1'b0, 32'h0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        check("midrst_push_valid", 64'(out_valid), 64'd1);
        check("midrst_push_pc", 64'(out_pc), 64'h200);
        check("midrst_push_count", 64'(count), 64'd1);
        out_ready = 1'b1;
        tick();
        check("midrst_final_empty", 64'(count), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
